// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
// Holds the FSM state encoding and the reset/step defaults used by the top level.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } pc_state_e;

  localparam logic [31:0] PC_STEP_DEFAULT      = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake and redirect bundle for the PC sequencer.
// The master modport is the sequencer; the slave modport is the memory/pipeline side.
interface pc_sequencer_if;

  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        misalign_err;
  logic [15:0] fetch_count;

  modport master (
    input  stall, branch_valid, branch_target, fetch_ready,
    output fetch_valid, fetch_addr, misalign_err, fetch_count
  );

  modport slave (
    output stall, branch_valid, branch_target, fetch_ready,
    input  fetch_valid, fetch_addr, misalign_err, fetch_count
  );

endinterface

// File: rtl/register_32bit.sv
// Plain 32-bit enabled register with no reset of its own.
// Reset values are loaded by the owner through d_in with en asserted.
module register_32bit (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] d_in,
  output logic [31:0] q_out
);

  always_ff @(posedge clk) begin
    if (en) begin
      q_out <= d_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: offers sequential fetch addresses, handles stall/redirect
// and counts accepted fetches.
//   state | meaning
//   BOOT  | first cycle after reset, nothing offered, branches ignored
//   ISSUE | fetch_valid high, current PC offered
//   HOLD  | stalled, nothing offered, branches still update the PC
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  pc_sequencer_if.master   bus
);

  pc_state_e   state_q, state_d;
  logic        misalign_err_q, misalign_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        accept;
  logic        branch_taken;

  assign bus.fetch_valid  = (state_q == ISSUE);
  assign bus.fetch_addr   = pc;
  assign bus.misalign_err = misalign_err_q;
  assign bus.fetch_count  = fetch_count_q;

  assign accept       = bus.fetch_valid && bus.fetch_ready;
  assign branch_taken = bus.branch_valid && (state_q != BOOT);

  // Every state leaves to ISSUE or HOLD purely on stall; BOOT is one cycle by construction.
  always_comb begin
    state_d = state_q;
    if (bus.stall) begin
      state_d = HOLD;
    end else begin
      state_d = ISSUE;
    end
  end

  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc;
    if (reset) begin
      pc_en = 1'b1;
      pc_d  = RESET_VECTOR;
    end else if (branch_taken) begin
      pc_en = 1'b1;
      pc_d  = word_align(bus.branch_target);
    end else if (accept) begin
      pc_en = 1'b1;
      pc_d  = pc + PC_STEP;
    end
  end

  always_comb begin
    misalign_err_d = branch_taken && (bus.branch_target[1:0] != 2'b00);
    fetch_count_d  = fetch_count_q;
    if (accept) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= BOOT;
      misalign_err_q <= 1'b0;
      fetch_count_q  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      misalign_err_q <= misalign_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  register_32bit u_pc_reg (
    .clk   (clk),
    .en    (pc_en),
    .d_in  (pc_d),
    .q_out (pc)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with fixed expectations
// plus a randomized run compared against a cycle-level behavioural model.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_err;
  logic        m_offer;
  logic        m_boot;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Applies one cycle of inputs at the falling edge, advances the model, and
  // returns at the next falling edge with outputs settled.
  task automatic tick(input logic r, input logic st, input logic bv,
                      input logic [31:0] bt, input logic rdy);
    logic accepted;
    logic taken;
    reset             = r;
    bus.stall         = st;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
    bus.fetch_ready   = rdy;
    accepted = m_offer && rdy;
    taken    = bv && !m_boot;
    if (r) begin
      m_pc = 32'h0; m_cnt = 16'h0; m_err = 1'b0; m_offer = 1'b0; m_boot = 1'b1;
    end else begin
      m_err = taken && (bt[1:0] != 2'b00);
      if (taken) m_pc = bt & 32'hFFFF_FFFC;
      else if (accepted) m_pc = m_pc + 32'd4;
      if (accepted) m_cnt = m_cnt + 16'd1;
      m_offer = !st;
      m_boot  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b1, 32'h0000_0123, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0456, 1'b1);
    n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.fetch_valid); end
    n_checks++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus.fetch_addr); end
    n_checks++; if (bus.fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", bus.fetch_count); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.misalign_err); end
  endtask

  task automatic test_sequential();
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL seq_boot_valid: got %b expected 0", bus.fetch_valid); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, bus.fetch_valid); end
      n_checks++; if (bus.fetch_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, bus.fetch_addr, 32'(i * 4)); end
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    n_checks++; if (bus.fetch_count !== 16'd4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", bus.fetch_count); end
  endtask

  task automatic test_ready_stall();
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL notready_addr[%0d]: got %h expected 00000000", i, bus.fetch_addr); end
      n_checks++; if (bus.fetch_count !== 16'h0) begin n_fail++; $display("FAIL notready_count[%0d]: got %0d expected 0", i, bus.fetch_count); end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h4) begin n_fail++; $display("FAIL ready_addr: got %h expected 00000004", bus.fetch_addr); end
    n_checks++; if (bus.fetch_count !== 16'd1) begin n_fail++; $display("FAIL ready_count: got %0d expected 1", bus.fetch_count); end
  endtask

  task automatic test_branch_accept();
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h8) begin n_fail++; $display("FAIL br_pre_addr: got %h expected 00000008", bus.fetch_addr); end
    tick(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h1000) begin n_fail++; $display("FAIL br_addr: got %h expected 00001000", bus.fetch_addr); end
    n_checks++; if (bus.fetch_count !== 16'd3) begin n_fail++; $display("FAIL br_count: got %0d expected 3", bus.fetch_count); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL br_err: got %b expected 0", bus.misalign_err); end
  endtask

  task automatic test_misaligned();
    tick(1'b0, 1'b0, 1'b1, 32'h0000_2002, 1'b0);
    n_checks++; if (bus.fetch_addr !== 32'h2000) begin n_fail++; $display("FAIL mis_addr: got %h expected 00002000", bus.fetch_addr); end
    n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err_pulse: got %b expected 1", bus.misalign_err); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear: got %b expected 0", bus.misalign_err); end
    n_checks++; if (bus.fetch_addr !== 32'h2000) begin n_fail++; $display("FAIL mis_addr_hold: got %h expected 00002000", bus.fetch_addr); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    n_checks++; if (bus.fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre_addr: got %h expected fffffffc", bus.fetch_addr); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", bus.fetch_addr); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b expected 0", bus.misalign_err); end
    n_checks++; if (bus.fetch_count !== 16'd4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", bus.fetch_count); end
  endtask

  task automatic test_hold_branch_reset();
    // stall and ready together: the current address is still accepted this cycle
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h4) begin n_fail++; $display("FAIL stall_accept_addr: got %h expected 00000004", bus.fetch_addr); end
    n_checks++; if (bus.fetch_count !== 16'd5) begin n_fail++; $display("FAIL stall_accept_count: got %0d expected 5", bus.fetch_count); end
    n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid0: got %b expected 0", bus.fetch_valid); end
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid1: got %b expected 0", bus.fetch_valid); end
    n_checks++; if (bus.fetch_addr !== 32'h40) begin n_fail++; $display("FAIL hold_br_addr: got %h expected 00000040", bus.fetch_addr); end
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_count !== 16'd5) begin n_fail++; $display("FAIL hold_count: got %0d expected 5", bus.fetch_count); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %b expected 1", bus.fetch_valid); end
    n_checks++; if (bus.fetch_addr !== 32'h40) begin n_fail++; $display("FAIL resume_addr: got %h expected 00000040", bus.fetch_addr); end
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
    n_checks++; if (bus.fetch_count !== 16'd0) begin n_fail++; $display("FAIL holdrst_count: got %0d expected 0", bus.fetch_count); end
    n_checks++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL holdrst_addr: got %h expected 00000000", bus.fetch_addr); end
    tick(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    n_checks++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL boot_branch_ignored: got %h expected 00000000", bus.fetch_addr); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL boot_err: got %b expected 0", bus.misalign_err); end
    n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL boot_exit_valid: got %b expected 1", bus.fetch_valid); end
  endtask

  task automatic test_count_wrap();
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 65535; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_max: got %h expected ffff", bus.fetch_count); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.fetch_count !== 16'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h expected 0000", bus.fetch_count); end
    n_checks++; if (bus.fetch_addr !== 32'h0004_0000) begin n_fail++; $display("FAIL cnt_wrap_addr: got %h expected 00040000", bus.fetch_addr); end
  endtask

  task automatic test_random();
    logic        r, st, bv, rdy;
    logic [31:0] bt;
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      bv  = ($urandom_range(0, 5) == 0);
      rdy = $urandom_range(0, 1) == 1;
      bt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      tick(r, st, bv, bt, rdy);
      n_checks++; if (bus.fetch_valid !== m_offer) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.fetch_valid, m_offer); end
      n_checks++; if (bus.fetch_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, bus.fetch_addr, m_pc); end
      n_checks++; if (bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d]: got %h expected %h", i, bus.fetch_count, m_cnt); end
      n_checks++; if (bus.misalign_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, bus.misalign_err, m_err); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_pc = 32'h0; m_cnt = 16'h0; m_err = 1'b0; m_offer = 1'b0; m_boot = 1'b1;
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'h0;
    bus.fetch_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_ready_stall();
    test_branch_accept();
    test_misaligned();
    test_wrap();
    test_hold_branch_reset();
    test_random();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
